// File: rtl/stream_pkg.sv
// Shared stream helpers: width helper and the beat-with-last payload used by the
// serializer and the matching deserializer.
package stream_pkg;

  localparam int unsigned BEAT_W = 8;

  // Like $clog2 but never returns 0, so a count port always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic              last;
    logic [BEAT_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow valid/ready serializer: emits lanes 0..up_cnt of each accepted word,
// LSB lane first, flagging the final beat with dn_last.
module stream_serializer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned CNT_W      = clog2_min1(RATIO)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH*RATIO-1:0] up_bus,
  input  logic [CNT_W-1:0]            up_cnt,
  input  logic                        up_val,
  output logic                        up_rdy,
  output logic [DATA_WIDTH-1:0]       dn_bus,
  output logic                        dn_val,
  output logic                        dn_last,
  input  logic                        dn_rdy
);

  localparam int unsigned      WORD_W  = DATA_WIDTH * RATIO;
  localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(RATIO - 1);

  logic [WORD_W-1:0]     r_word;
  logic [CNT_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_end;
  logic [DATA_WIDTH-1:0] r_bus;
  logic                  r_val;
  logic                  r_last;

  logic                  w_up_acc;
  logic                  w_dn_acc;
  logic [CNT_W-1:0]      w_cnt;
  logic [DATA_WIDTH-1:0] w_lane;

  // Ready is combinational from dn_rdy so the next word loads under the last beat.
  assign up_rdy   = ~rst & (~r_val | (dn_rdy & r_last));
  assign w_up_acc = up_val & up_rdy;
  assign w_dn_acc = r_val & dn_rdy;

  // Zero-extended compare keeps the clamp meaningful for non-power-of-2 RATIO.
  assign w_cnt  = ({1'b0, up_cnt} > {1'b0, MAX_IDX}) ? MAX_IDX : up_cnt;
  assign w_lane = r_word[r_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
      r_end  <= '0;
      r_bus  <= '0;
      r_val  <= 1'b0;
      r_last <= 1'b0;
    end else if (w_up_acc) begin
      r_word <= up_bus;
      r_end  <= w_cnt;
      r_bus  <= up_bus[DATA_WIDTH-1:0];
      r_val  <= 1'b1;
      r_last <= (w_cnt == '0);
      r_idx  <= CNT_W'(1);
    end else if (w_dn_acc) begin
      if (r_last) begin
        r_val  <= 1'b0;
        r_last <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_bus  <= w_lane;
        r_last <= (r_idx == r_end);
        // Hold at the final lane instead of wrapping inside a word.
        r_idx  <= (r_idx == r_end) ? r_idx : r_idx + CNT_W'(1);
      end
    end
  end

  assign dn_bus  = r_bus;
  assign dn_val  = r_val;
  assign dn_last = r_last;

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: a beat-queue model fed from observed upstream handshakes,
// checked every cycle, plus directed literal expectations.
module tb_stream_serializer;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned CW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW*RATIO-1:0] up_bus = '0;
  logic [CW-1:0]     up_cnt = '0;
  logic              up_val = 1'b0;
  logic              up_rdy;
  logic [DW-1:0]     dn_bus;
  logic              dn_val;
  logic              dn_last;
  logic              dn_rdy = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_rdy = 1'b0;

  // Model: the ordered beats still owed downstream, each {last, data}.
  logic [DW:0] exp_q[$];
  logic [DW-1:0] log_data[$];
  logic          log_last[$];
  int            log_cyc[$];

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_bus   = '0;
  logic          prev_last  = 1'b0;

  stream_serializer #(.DATA_WIDTH(DW), .RATIO(RATIO), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .up_bus (up_bus),
    .up_cnt (up_cnt),
    .up_val (up_val),
    .up_rdy (up_rdy),
    .dn_bus (dn_bus),
    .dn_val (dn_val),
    .dn_last(dn_last),
    .dn_rdy (dn_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor/compare: inputs settle #1 after posedge, so negedge sees what the next edge sees.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("dn_val vs model", {63'd0, dn_val}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("dn_bus vs model", {56'd0, dn_bus}, {56'd0, exp_q[0][DW-1:0]});
        chk("dn_last vs model", {63'd0, dn_last}, {63'd0, exp_q[0][DW]});
      end
      if (prev_stall && !rst) begin
        chk("stall dn_bus stable", {56'd0, dn_bus}, {56'd0, prev_bus});
        chk("stall dn_last stable", {63'd0, dn_last}, {63'd0, prev_last});
      end
      if (rst) begin
        chk("up_rdy in reset", {63'd0, up_rdy}, 64'd0);
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        chk("up_rdy rule", {63'd0, up_rdy}, {63'd0, (!dn_val) || (dn_rdy && dn_last)});
        if (dn_val && dn_rdy && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          log_data.push_back(dn_bus);
          log_last.push_back(dn_last);
          log_cyc.push_back(cyc);
        end
        if (up_val && up_rdy) begin
          for (int k = 0; k <= int'(up_cnt); k++) begin
            logic [DW*RATIO-1:0] w;
            w = up_bus >> (k * DW);
            exp_q.push_back({k == int'(up_cnt), w[DW-1:0]});
          end
        end
        prev_stall = dn_val && !dn_rdy;
      end
      prev_bus  = dn_bus;
      prev_last = dn_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) dn_rdy = ($urandom_range(0, 99) < 30);
    end
  end

  task automatic send(input logic [31:0] w, input logic [CW-1:0] c);
    up_bus = w;
    up_cnt = c;
    up_val = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (up_rdy) break;
      if (t > 300) begin
        chk("send timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    up_val = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dn_val) break;
      if (t > 3000) begin
        chk("drain timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  task automatic chk_log(input string name, input logic [63:0] bytes, input logic [7:0] lasts,
                         input int n);
    chk({name, " beat count"}, 64'(log_data.size()), 64'(n));
    if (log_data.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, " beat data"}, {56'd0, log_data[i]}, {56'd0, bytes[i*8 +: 8]});
        chk({name, " beat last"}, {63'd0, log_last[i]}, {63'd0, lasts[i]});
      end
      chk({name, " no gaps"}, 64'(log_cyc[n-1] - log_cyc[0]), 64'(n - 1));
    end
  endtask

  initial begin
    int exp_beats;
    // 1. Reset held 3 cycles with up_val asserted.
    up_bus = 32'h12345678;
    up_cnt = 2'd3;
    up_val = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("up_rdy after reset", {63'd0, up_rdy}, 64'd1);
    chk("dn_val after reset", {63'd0, dn_val}, 64'd0);
    chk("dn_bus after reset", {56'd0, dn_bus}, 64'd0);
    @(posedge clk);
    #1;
    up_val = 1'b0;
    drain();
    clear_log();

    // 2. Full word.
    send(32'hDDCCBBAA, 2'd3);
    drain();
    chk_log("full", 64'hDDCCBBAA, 8'b1000, 4);
    clear_log();

    // 3. Back-to-back words.
    send(32'h04030201, 2'd3);
    send(32'h08070605, 2'd3);
    drain();
    chk_log("b2b", 64'h0807060504030201, 8'b10001000, 8);
    clear_log();

    // 4. Partial words.
    send(32'hEEEEEE5A, 2'd0);
    send(32'hFFFF3C2B, 2'd1);
    drain();
    chk_log("partial", 64'h3C2B5A, 8'b101, 3);
    clear_log();

    // 5. Random backpressure.
    exp_beats = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      exp_beats += int'(c) + 1;
      send($urandom, c);
    end
    rand_rdy = 1'b0;
    dn_rdy = 1'b1;
    drain();
    chk("random beat total", 64'(log_data.size()), 64'(exp_beats));
    clear_log();

    // 6. Reset in the middle of a word.
    send(32'hDDCCBBAA, 2'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset dn_val", {63'd0, dn_val}, 64'd0);
    chk("midreset dn_last", {63'd0, dn_last}, 64'd0);
    repeat (3) @(negedge clk);
    chk_log("midreset head", 64'hBBAA, 8'b00, 2);
    clear_log();
    @(posedge clk);
    #1;
    send(32'h44332211, 2'd3);
    drain();
    chk_log("after reset", 64'h44332211, 8'b1000, 4);
    chk("model empty at end", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
